fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_pc_reg.sv | 25 ++
 rtl/fetch.sv | 60 ++++++
 tb/tb_fetch.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned PC_INC   = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// pc_reg: N-bit register with synchronous active-high reset and load enable.
// Reset takes priority over the enable.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      W         = ADDR_W,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register update: reset wins, otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch.sv
// fetch: program counter and next-PC selection for the fetch stage.
// imem_addr_F is the PC register itself (no output delay). The next PC is either
// PC + PC_INC (wrapping modulo 2^N) or the unmodified branch target.
// Optional feature: define FETCH_STALL_EN to add a stall_F input after imem_addr_F;
// a stall holds the PC unless a branch is taken in the same cycle.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = fetch_pkg::ADDR_W,
    parameter int unsigned  PC_INC   = fetch_pkg::PC_INC,
    parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC)
) (
    input  logic         PCSrc_F,
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCBranch_F,
`ifdef FETCH_STALL_EN
    output logic [N-1:0] imem_addr_F,
    input  logic         stall_F
`else
    output logic [N-1:0] imem_addr_F
`endif
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_seq;
    logic [N-1:0] pc_d;
    logic         pc_en;

    // Next-PC selection: sequential increment or branch target, taken as-is.
    always_comb begin
        pc_seq = pc_q + N'(PC_INC);
        pc_d   = PCSrc_F ? PCBranch_F : pc_seq;
    end

    // Load enable: a taken branch overrides a stall.
`ifdef FETCH_STALL_EN
    always_comb begin
        pc_en = PCSrc_F | ~stall_F;
    end
`else
    always_comb begin
        pc_en = 1'b1;
    end
`endif

    pc_reg #(
        .W         (N),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    assign imem_addr_F = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: a behavioural PC model checked every falling edge, plus
// directed steps with hand-computed literal expectations.
module tb_fetch;

    logic        clk;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic [63:0] imem_addr_F;
    logic        stall_F;

    int n_checks;
    int n_fail;

    longint unsigned mdl_pc;
    bit              mdl_valid;

`ifdef FETCH_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    fetch dut (
        .PCSrc_F     (PCSrc_F),
        .clk         (clk),
        .reset       (reset),
        .PCBranch_F  (PCBranch_F),
`ifdef FETCH_STALL_EN
        .imem_addr_F (imem_addr_F),
        .stall_F     (stall_F)
`else
        .imem_addr_F (imem_addr_F)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what the PC must become at each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            mdl_pc    <= 64'h0;
            mdl_valid <= 1'b1;
        end else if (PCSrc_F) begin
            mdl_pc <= PCBranch_F;
        end else if (STALL_EN && stall_F) begin
            mdl_pc <= mdl_pc;
        end else begin
            mdl_pc <= mdl_pc + 64'd4;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mdl_valid) begin
            n_checks++;
            if (imem_addr_F !== mdl_pc) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, imem_addr_F, mdl_pc);
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] exp);
        n_checks++;
        if (imem_addr_F !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, imem_addr_F, exp);
        end
    endtask

    // Drive inputs at the falling edge, then check 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic src, input logic [63:0] br,
                        input logic stl, input string name, input logic [63:0] exp);
        @(negedge clk);
        reset      = rst;
        PCSrc_F    = src;
        PCBranch_F = br;
        stall_F    = stl;
        @(posedge clk);
        #1;
        check_lit(name, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mdl_valid  = 1'b0;
        mdl_pc     = 64'h0;
        reset      = 1'b1;
        PCSrc_F    = 1'b0;
        PCBranch_F = 64'h0;
        stall_F    = 1'b0;

        // Reset held for 5 cycles.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'h0, 1'b0, "reset_hold", 64'h0);

        // Sequential run after release.
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b0, 64'h0, 1'b0, "seq_run", 64'(4 * i));

        // Branch then sequential.
        step(1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, "branch", 64'hAAAA_BBBB_CCCC_DDDD);
        step(1'b0, 1'b0, 64'h0, 1'b0, "branch_seq", 64'hAAAA_BBBB_CCCC_DDE1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, "branch_top", 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, 1'b0, 64'h0, 1'b0, "wrap", 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b0, "after_wrap", 64'h4);

        // Reset and branch at the same edge: reset wins.
        step(1'b1, 1'b1, 64'h0000_0000_0000_1234, 1'b0, "reset_vs_branch", 64'h0);

        // First edge after reset with a branch loads the target.
        step(1'b0, 1'b1, 64'h40, 1'b0, "first_edge_branch", 64'h40);

        // Misaligned target is loaded unmodified.
        step(1'b0, 1'b1, 64'h13, 1'b0, "misaligned", 64'h13);
        step(1'b0, 1'b0, 64'h0, 1'b0, "misaligned_seq", 64'h17);

        // Mid-run reset: no effect before the edge, PC = 0 after it.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_lit("reset_pre_edge", 64'h17);
        @(posedge clk);
        #1;
        check_lit("reset_mid_run", 64'h0);

        // PCSrc_F glitch between edges must not matter.
        @(negedge clk);
        reset      = 1'b0;
        PCSrc_F    = 1'b1;
        PCBranch_F = 64'h999;
        #2;
        PCSrc_F    = 1'b0;
        @(posedge clk);
        #1;
        check_lit("glitch", 64'h4);
        step(1'b0, 1'b0, 64'h0, 1'b0, "pc_8", 64'h8);

`ifdef FETCH_STALL_EN
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1, "stall_hold", 64'h8);
        step(1'b0, 1'b1, 64'h100, 1'b1, "stall_branch", 64'h100);
        step(1'b0, 1'b0, 64'h0, 1'b0, "stall_release", 64'h104);
        step(1'b1, 1'b0, 64'h0, 1'b1, "stall_reset", 64'h0);
`else
        step(1'b0, 1'b0, 64'h0, 1'b0, "no_stall_seq", 64'hC);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
